// File: rtl/arth_seq_unit.sv
// Multi-cycle sign-and-magnitude arithmetic unit: add/sub in one cycle, shift-add multiply
// and (with ARTH_DIV_EN defined) restoring divide over MAG_W iterations.
module arth_seq_unit #(
  parameter int unsigned MAG_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [MAG_W:0]   V1,
  input  logic [MAG_W:0]   V2,
  input  logic [1:0]       opcode,
  input  logic             newop,
  output logic [MAG_W:0]   answer,
  output logic             ovw,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(MAG_W + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAddSub = 2'd1;
  localparam logic [1:0] StIter   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               sgn1_q, sgn1_d, sgn2_q, sgn2_d;
  logic [MAG_W-1:0]   mag1_q, mag1_d;
  logic [2*MAG_W-1:0] prod_q, prod_d;
  logic [MAG_W:0]     answer_q, answer_d;
  logic               ovw_q, ovw_d;
  logic               done_q, done_d;

  logic [MAG_W+1:0]   as_a1, as_a2, as_res, as_mag;
  logic               as_neg;
  logic [MAG_W:0]     mul_sum;
  logic [2*MAG_W-1:0] mul_next, iter_next;
  logic [MAG_W-1:0]   it_mag;
  logic               it_ovw;
`ifdef ARTH_DIV_EN
  logic [MAG_W:0]     div_shift;
  logic [MAG_W-1:0]   div_rem;
  logic               div_ge;
  logic [2*MAG_W-1:0] div_next;
`endif

  // prod_q low half holds |V2| until the op starts; add/sub reads operand 2 from there.
  always_comb begin
    as_a1  = sgn1_q ? -{2'b00, mag1_q} : {2'b00, mag1_q};
    as_a2  = sgn2_q ? -{2'b00, prod_q[MAG_W-1:0]} : {2'b00, prod_q[MAG_W-1:0]};
    as_res = (op_q == 2'b10) ? (as_a2 - as_a1) : (as_a1 + as_a2);
    as_neg = as_res[MAG_W+1];
    as_mag = as_neg ? -as_res : as_res;

    mul_sum  = {1'b0, prod_q[2*MAG_W-1:MAG_W]} + (prod_q[0] ? {1'b0, mag1_q} : '0);
    mul_next = {mul_sum, prod_q[MAG_W-1:1]};

`ifdef ARTH_DIV_EN
    // {remainder, quotient} share prod_q; the dividend shifts out of the low half.
    div_shift = {prod_q[2*MAG_W-1:MAG_W], prod_q[MAG_W-1]};
    div_ge    = div_shift >= {1'b0, mag1_q};
    div_rem   = div_shift[MAG_W-1:0] - mag1_q;
    div_next  = div_ge ? {div_rem, prod_q[MAG_W-2:0], 1'b1}
                       : {div_shift[MAG_W-1:0], prod_q[MAG_W-2:0], 1'b0};
    iter_next = (op_q == 2'b01) ? mul_next : div_next;
    if (op_q == 2'b01) begin
      it_mag = iter_next[MAG_W-1:0];
      it_ovw = |iter_next[2*MAG_W-1:MAG_W];
    end else if (mag1_q == '0) begin
      it_mag = '0;
      it_ovw = 1'b1;
    end else begin
      it_mag = iter_next[MAG_W-1:0];
      it_ovw = 1'b0;
    end
`else
    iter_next = mul_next;
    it_mag    = iter_next[MAG_W-1:0];
    it_ovw    = |iter_next[2*MAG_W-1:MAG_W];
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sgn1_d   = sgn1_q;
    sgn2_d   = sgn2_q;
    mag1_d   = mag1_q;
    prod_d   = prod_q;
    answer_d = answer_q;
    ovw_d    = ovw_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (newop) begin
          op_d   = opcode;
          sgn1_d = V1[MAG_W];
          sgn2_d = V2[MAG_W];
          mag1_d = V1[MAG_W-1:0];
          prod_d = {{MAG_W{1'b0}}, V2[MAG_W-1:0]};
          cnt_d  = CNT_W'(MAG_W);
`ifdef ARTH_DIV_EN
          state_d = opcode[0] ? StIter : StAddSub;
`else
          state_d = (opcode == 2'b01) ? StIter : StAddSub;
`endif
        end
      end
      StAddSub: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (op_q == 2'b11) begin
          // Divide compiled out: flag as invalid operator.
          answer_d = '0;
          ovw_d    = 1'b1;
        end else begin
          answer_d = {as_neg && (|as_mag[MAG_W-1:0]), as_mag[MAG_W-1:0]};
          ovw_d    = |as_mag[MAG_W+1:MAG_W];
        end
      end
      StIter: begin
        prod_d = iter_next;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = StIdle;
          done_d   = 1'b1;
          answer_d = {(sgn1_q ^ sgn2_q) && (|it_mag), it_mag};
          ovw_d    = it_ovw;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      sgn1_q   <= 1'b0;
      sgn2_q   <= 1'b0;
      mag1_q   <= '0;
      prod_q   <= '0;
      answer_q <= '0;
      ovw_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sgn1_q   <= sgn1_d;
      sgn2_q   <= sgn2_d;
      mag1_q   <= mag1_d;
      prod_q   <= prod_d;
      answer_q <= answer_d;
      ovw_q    <= ovw_d;
      done_q   <= done_d;
    end
  end

  assign answer = answer_q;
  assign ovw    = ovw_q;
  assign busy   = (state_q != StIdle);
  assign done   = done_q;

endmodule

// File: tb/tb_arth_seq_unit.sv
// Directed self-checking bench for arth_seq_unit (MAG_W=16); ARTH_DIV_EN selects divide checks.
module tb_arth_seq_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [16:0] V1, V2;
  logic [1:0]  opcode;
  logic        newop;
  logic [16:0] answer;
  logic        ovw, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int dones;

  arth_seq_unit #(.MAG_W(16)) dut (
    .clock  (clock),
    .reset  (reset),
    .V1     (V1),
    .V2     (V2),
    .opcode (opcode),
    .newop  (newop),
    .answer (answer),
    .ovw    (ovw),
    .busy   (busy),
    .done   (done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one newop strobe; returns #1 after the accepting edge.
  task automatic issue(input logic [16:0] a, input logic [16:0] b, input logic [1:0] op);
    V1 = a; V2 = b; opcode = op; newop = 1'b1;
    tick();
    newop = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      cycles++;
      if (done) return;
    end
    cycles = 99;
  endtask

  initial begin
    reset = 1'b1; V1 = '0; V2 = '0; opcode = 2'b00; newop = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_answer", 32'(answer), 32'h0);
    check("rst_ovw", 32'(ovw), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);

    // +5 + -12 = -7
    issue(17'h00005, 17'h1000C, 2'b00);
    check("add_busy", 32'(busy), 32'h1);
    check("add_done_early", 32'(done), 32'h0);
    tick();
    check("add_done", 32'(done), 32'h1);
    check("add_busy_off", 32'(busy), 32'h0);
    check("add_answer", 32'(answer), 32'h10007);
    check("add_ovw", 32'(ovw), 32'h0);
    tick();
    check("add_done_pulse", 32'(done), 32'h0);
    check("add_hold", 32'(answer), 32'h10007);

    // +40000 - (-40000) = 80000 -> 14464 with overflow
    issue(17'h19C40, 17'h09C40, 2'b10);
    wait_done(cyc);
    check("sub_ovf_lat", 32'(cyc), 32'd1);
    check("sub_ovf_answer", 32'(answer), 32'h03880);
    check("sub_ovf_ovw", 32'(ovw), 32'h1);

    issue(17'h00007, 17'h00007, 2'b10);
    wait_done(cyc);
    check("sub_zero_answer", 32'(answer), 32'h00000);
    check("sub_zero_ovw", 32'(ovw), 32'h0);

    // -65535 + -1 = -65536: truncates to zero, no negative zero
    issue(17'h1FFFF, 17'h10001, 2'b00);
    wait_done(cyc);
    check("add_ovf_answer", 32'(answer), 32'h00000);
    check("add_ovf_ovw", 32'(ovw), 32'h1);

    // -300 * +200 = -60000
    issue(17'h1012C, 17'h000C8, 2'b01);
    check("mul_busy", 32'(busy), 32'h1);
    wait_done(cyc);
    check("mul_lat", 32'(cyc), 32'd16);
    check("mul_answer", 32'(answer), 32'h1EA60);
    check("mul_ovw", 32'(ovw), 32'h0);

    // +256 * +256 overflows; newop pulses mid-op must be ignored
    issue(17'h00100, 17'h00100, 2'b01);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 3 || i == 7) begin
        V1 = 17'h00001; V2 = 17'h00001; opcode = 2'b00; newop = 1'b1;
      end
      tick();
      newop = 1'b0;
      cyc++;
      if (done) break;
    end
    check("mul_ign_lat", 32'(cyc), 32'd16);
    check("mul_ovf_answer", 32'(answer), 32'h00000);
    check("mul_ovf_ovw", 32'(ovw), 32'h1);

    // Back-to-back: issue in the done cycle
    issue(17'h00002, 17'h00003, 2'b00);
    check("b2b_busy", 32'(busy), 32'h1);
    tick();
    check("b2b_done", 32'(done), 32'h1);
    check("b2b_answer", 32'(answer), 32'h00005);
    check("b2b_ovw", 32'(ovw), 32'h0);

`ifdef ARTH_DIV_EN
    // -1000 / +7 = -142
    issue(17'h00007, 17'h103E8, 2'b11);
    wait_done(cyc);
    check("div_lat", 32'(cyc), 32'd16);
    check("div_answer", 32'(answer), 32'h1008E);
    check("div_ovw", 32'(ovw), 32'h0);
    issue(17'h00000, 17'h00005, 2'b11);
    wait_done(cyc);
    check("div0_lat", 32'(cyc), 32'd16);
    check("div0_answer", 32'(answer), 32'h00000);
    check("div0_ovw", 32'(ovw), 32'h1);
`else
    issue(17'h00003, 17'h00009, 2'b11);
    wait_done(cyc);
    check("op11_lat", 32'(cyc), 32'd1);
    check("op11_answer", 32'(answer), 32'h00000);
    check("op11_ovw", 32'(ovw), 32'h1);
`endif

    // Leave a nonzero result, then reset a multiply at iteration 8
    issue(17'h00002, 17'h00003, 2'b00);
    wait_done(cyc);
    check("pre_rst_answer", 32'(answer), 32'h00005);
    issue(17'h00003, 17'h00005, 2'b01);
    repeat (7) tick();
    reset = 1'b1;
    V1 = 17'h00001; V2 = 17'h00001; opcode = 2'b00; newop = 1'b1;
    tick();
    reset = 1'b0;
    newop = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_done", 32'(done), 32'h0);
    check("mid_rst_answer", 32'(answer), 32'h00000);
    check("mid_rst_ovw", 32'(ovw), 32'h0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) dones++;
    end
    check("mid_rst_no_done", 32'(dones), 32'd0);
    check("mid_rst_idle", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arth_seq_unit.md
# arth_seq_unit

Parametrised, multi-cycle sign-and-magnitude arithmetic unit; successor to the single-cycle calculator datapath. Operands and result are MAG_W-bit magnitudes with a sign bit on top. Adds a start/busy/done handshake, iterative shift-add multiply, and optional restoring divide. Sits between the keypad/operand registers and the display driver.

## Interface
- MAG_W, 16, magnitude width in bits; operand/result width is MAG_W+1 with the sign in the MSB.
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state and outputs.
- V1  in  MAG_W+1  operand 1, sign and magnitude.
- V2  in  MAG_W+1  operand 2, sign and magnitude.
- opcode  in  2  00 add V1+V2, 01 multiply V1*V2, 10 subtract V2-V1, 11 divide V2/V1.
- newop  in  1  start strobe; samples V1, V2, opcode when accepted.
- answer  out  MAG_W+1  registered result, sign and magnitude; holds until next result.
- ovw  out  1  registered overflow/error flag, qualifies answer.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; answer/ovw newly valid.

## Operation
- States: IDLE, ADDSUB, ITER. done is a registered pulse, not a state.
- IDLE: newop=1 captures V1, V2, opcode into internal registers; go to ADDSUB (00, 10, or 11 when divide is compiled out) or ITER (01, or 11 with divide); ITER loads counter with MAG_W.
- newop while busy=1: ignored; no queueing, operands not re-sampled.
- Add/sub: operands converted to MAG_W+2-bit two's complement; result magnitude computed exactly; ovw=1 iff magnitude > 2^MAG_W-1; answer magnitude = low MAG_W bits of true magnitude; sign from true result.
- Multiply: shift-add over MAG_W iterations, one multiplier bit per cycle, 2*MAG_W-bit accumulator; answer magnitude = low MAG_W bits; ovw = OR of upper MAG_W bits; sign = V1 sign XOR V2 sign.
- Divide: restoring, one quotient bit per iteration, MAG_W iterations; magnitude = floor(|V2|/|V1|); remainder discarded; sign = XOR; ovw=0. |V1|=0: answer 0, ovw=1, same latency.
- Zero rule: any result with zero magnitude (including overflow truncation) has sign 0; no negative zero on answer. Inputs of -0 accepted as 0.
- After final cycle: answer, ovw written; done=1; state IDLE.

## Timing
- Reset values: answer=0, ovw=0, busy=0, done=0, state IDLE, counter 0.
- newop sampled at edge N. busy=1 from edge N until edge of completion.
- Add/sub: result written at edge N+1; done=1, busy=0 for the cycle after N+1. Latency 1.
- Multiply/divide: iterations at edges N+1..N+MAG_W; result written at edge N+MAG_W; latency MAG_W.
- During the done cycle busy=0 and newop is accepted (back-to-back issue, one op per latency+0 idle cycles).
- Reset asserted mid-operation: at that edge state returns to IDLE, busy, done, answer, ovw cleared; in-flight result discarded; newop coincident with reset ignored.
- answer/ovw stable from done until the next done or reset.

## Configuration
- ARTH_DIV_EN defined: opcode 11 performs iterative divide as above, latency MAG_W.
- ARTH_DIV_EN undefined: divider logic absent; opcode 11 completes via ADDSUB path with latency 1, answer=0, ovw=1 (invalid operator).

## Test plan
- MAG_W=16, reset then idle: all outputs 0; newop with opcode 00, V1=+5, V2=-12 -> one cycle later done=1, answer=-7 (17'h10007), ovw=0.
- Subtract overflow: V1=-40000 (17'h19C40), V2=+40000, opcode 10 -> answer magnitude 80000 mod 65536 = 14464, sign 0, ovw=1; V1=+7, V2=+7 -> answer 17'h00000, ovw=0 (no -0).
- Multiply: V1=-300, V2=+200, opcode 01 -> done exactly 16 cycles after newop, answer=-60000, ovw=0; V1=+256, V2=+256 -> answer 0, sign 0, ovw=1.
- Divide (ARTH_DIV_EN): V2=-1000, V1=+7 -> after 16 cycles answer=-142, ovw=0; V1=0 -> answer 0, ovw=1; undefined macro: opcode 11 -> done after 1 cycle, answer 0, ovw=1.
- Handshake: newop pulses during busy of a multiply are ignored (answer reflects first op only); newop in the done cycle starts next op, busy=1 next cycle.
- Reset at iteration 8 of a multiply -> next cycle busy=0, done=0, answer=0, ovw=0; no done pulse follows.
